// File: rtl/toggle_event_arbiter_pkg.sv
// toggle_evt_pkg: shared FSM state type and round-robin search for toggle_event_arbiter
package toggle_evt_pkg;
  typedef enum logic {S_IDLE, S_OFFER} arb_state_e;
  localparam int MAX_REQ = 16;
  // Returns {found, idx}: first set bit of pend at or after ptr, wrapping at n.
  // Offsets are walked high to low so the smallest offset is the one left standing.
  function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] pend, input logic [3:0] ptr,
                                         input int n);
    logic [4:0] r;
    int j;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j -= n;
        if (pend[4'(j)]) r = {1'b1, 4'(j)};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/toggle_event_arbiter_if.sv
// toggle_event_arbiter_if: event-port bundle between async sources/consumer and the arbiter
//   req_tgl/ack_tgl   per-source toggle handshake
//   out_valid/out_id/out_ready   serialised event port
//   overrun/overrun_clr   sticky drop flags and their W1C clear
interface toggle_event_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_tgl;
  logic [NUM_REQ-1:0] ack_tgl;
  logic               out_valid;
  logic [ID_W-1:0]    out_id;
  logic               out_ready;
  logic [NUM_REQ-1:0] overrun;
  logic [NUM_REQ-1:0] overrun_clr;
  modport master (output req_tgl, out_ready, overrun_clr, input ack_tgl, out_valid, out_id, overrun);
  modport slave (input req_tgl, out_ready, overrun_clr, output ack_tgl, out_valid, out_id, overrun);
endinterface

// File: rtl/toggle_event_arbiter_sync.sv
// sync_chain_arn: STAGES-deep synchroniser, async active-low reset to 0
//   clk, rst_n   clock and reset
//   i_d          asynchronous input
//   o_q          synchronised output
module sync_chain_arn #(parameter int STAGES = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= {r_q[STAGES-2:0], i_d};
  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/toggle_event_arbiter.sv
// toggle_event_arbiter: serialises toggle events from async sources onto one valid/ready port, round robin
//   clk, rst_n   single clock, async active-low reset
//   bus          toggle_event_arbiter_if.slave (req/ack toggles, event port, overrun flags)
module toggle_event_arbiter
  import toggle_evt_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SYNC_STAGE = 4
) (
  input logic clk,
  input logic rst_n,
  toggle_event_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] w_sync, w_evt, w_acc_vec, r_hist, r_pend, r_ovr, r_ack;
  arb_state_e r_state, w_nstate;
  logic r_valid, w_nvalid, w_acc;
  logic [ID_W-1:0] r_id, w_nid, r_ptr, w_nptr;
  logic [4:0] w_pick;
  genvar i;
  for (i = 0; i < NUM_REQ; i++) begin : g_sync
    sync_chain_arn #(.STAGES(SYNC_STAGE)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.req_tgl[i]), .o_q(w_sync[i]));
  end
  assign w_evt = w_sync ^ r_hist;
  assign w_acc = r_valid && bus.out_ready;
  assign w_acc_vec = w_acc ? NUM_REQ'(1) << r_id : '0;
  assign w_pick = rr_pick(MAX_REQ'(r_pend), 4'(r_ptr), NUM_REQ);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hist  <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
      r_ack   <= '0;
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_hist  <= w_sync;
      r_pend  <= (r_pend & ~w_acc_vec) | w_evt;
      // a new event on a source that is pending and not leaving is dropped; set beats clear
      r_ovr   <= (r_ovr & ~bus.overrun_clr) | (w_evt & r_pend & ~w_acc_vec);
      r_ack   <= r_ack ^ w_acc_vec;
      r_state <= w_nstate;
      r_valid <= w_nvalid;
      r_id    <= w_nid;
      r_ptr   <= w_nptr;
    end
  always_comb begin
    w_nstate = r_state;
    w_nvalid = r_valid;
    w_nid    = r_id;
    w_nptr   = r_ptr;
    if (r_state == S_IDLE && w_pick[4]) begin
      w_nstate = S_OFFER;
      w_nvalid = 1'b1;
      w_nid    = w_pick[ID_W-1:0];
    end else if (r_state == S_OFFER && bus.out_ready) begin
      w_nstate = S_IDLE;
      w_nvalid = 1'b0;
      w_nptr   = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
    end
  end
  assign bus.ack_tgl   = r_ack;
  assign bus.out_valid = r_valid;
  assign bus.out_id    = r_id;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_toggle_event_arbiter.sv
// tb_toggle_event_arbiter: directed scoreboard bench for toggle_event_arbiter
module tb_toggle_event_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];
  toggle_event_arbiter_if #(.NUM_REQ(4)) bus ();
  toggle_event_arbiter #(.NUM_REQ(4), .SYNC_STAGE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event", {30'd0, bus.out_id}, 32'hffff_ffff);
      else chk("event_id", {30'd0, bus.out_id}, {30'd0, exp_q.pop_front()});
    end
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_tgl = '0;
    bus.out_ready = 1'b0;
    bus.overrun_clr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drive_next();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask
  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask
  initial begin
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_ovr", bus.overrun, 0);
      chk("idle_ack", bus.ack_tgl, 0);
    end
    bus.out_ready = 1'b1;
    exp_q.push_back(2);
    drive_next();
    bus.req_tgl[2] = ~bus.req_tgl[2];
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_valid_e%0d", k), bus.out_valid, (k == 5));
      if (k == 5) chk("lat_id", bus.out_id, 2);
    end
    chk("lat_ack2", bus.ack_tgl[2], 1);
    wait_drain();
    do_reset();
    bus.out_ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    drive_next();
    bus.req_tgl = bus.req_tgl ^ 4'b1011;
    wait_drain();
    chk("multi_ack", bus.ack_tgl, 4'b1011);
    exp_q.push_back(0);
    exp_q.push_back(3);
    drive_next();
    bus.req_tgl = bus.req_tgl ^ 4'b1001;
    wait_drain();
    chk("ptr_wrap_ack", bus.ack_tgl, 4'b0010);
    do_reset();
    drive_next();
    bus.req_tgl[1] = ~bus.req_tgl[1];
    wait_valid();
    drive_next();
    bus.req_tgl[0] = ~bus.req_tgl[0];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", k), {bus.out_valid, bus.out_id}, 3'b101);
    end
    exp_q.push_back(1);
    exp_q.push_back(0);
    drive_next();
    bus.out_ready = 1'b1;
    wait_drain();
    chk("hold_ack", bus.ack_tgl, 4'b0011);
    do_reset();
    drive_next();
    bus.req_tgl[0] = ~bus.req_tgl[0];
    wait_valid();
    chk("ovr_before", bus.overrun, 0);
    drive_next();
    bus.req_tgl[0] = ~bus.req_tgl[0];
    repeat (3) drive_next();
    bus.req_tgl[0] = ~bus.req_tgl[0];
    repeat (8) @(negedge clk);
    chk("ovr_set", bus.overrun, 4'b0001);
    exp_q.push_back(0);
    drive_next();
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (15) @(negedge clk);
    chk("ovr_single_valid", bus.out_valid, 0);
    chk("ovr_ack", bus.ack_tgl, 4'b0001);
    chk("ovr_sticky", bus.overrun, 4'b0001);
    drive_next();
    bus.overrun_clr = 4'b0001;
    drive_next();
    bus.overrun_clr = '0;
    chk("ovr_clr", bus.overrun, 0);
    do_reset();
    drive_next();
    bus.req_tgl[2] = ~bus.req_tgl[2];
    wait_valid();
    chk("rst_offer_id", bus.out_id, 2);
    #1;
    rst_n = 1'b0;
    bus.req_tgl = '0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_ack", bus.ack_tgl, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_event", bus.out_valid, 0);
    chk("rst_ack_after", bus.ack_tgl, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
